// File: rtl/io_port_ctrl_if.sv
// Bundle of core-side and device-side signals for io_port_ctrl.
// Latency: none; this is wiring only.
// Backpressure: the core holds in_req until in_ready; device pushes are never stalled.
// Ports: dev_in/enter_in (device in), dev_out/enter_out (device out),
//        in_req/in_ch/in_ready/in_data (core read), new_out/out_ch/out_data (core write),
//        fifo_empty/fifo_full status, overflow only when IO_PORT_OVERFLOW_EN is defined.
interface io_port_ctrl_if #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 32
);
  localparam int CH_W = $clog2(N_CH);

  logic [N_CH*DATA_W-1:0] dev_in;
  logic [N_CH-1:0]        enter_in;
  logic                   in_req;
  logic [CH_W-1:0]        in_ch;
  logic                   in_ready;
  logic [DATA_W-1:0]      in_data;
  logic                   new_out;
  logic [CH_W-1:0]        out_ch;
  logic [DATA_W-1:0]      out_data;
  logic [N_CH*DATA_W-1:0] dev_out;
  logic [N_CH-1:0]        enter_out;
  logic [N_CH-1:0]        fifo_empty;
  logic [N_CH-1:0]        fifo_full;
`ifdef IO_PORT_OVERFLOW_EN
  logic [N_CH-1:0]        overflow;
`endif

  // Core/device side: drives the controller inputs.
  modport master (
    output dev_in, enter_in, in_req, in_ch, new_out, out_ch, out_data,
    input  in_ready, in_data, dev_out, enter_out, fifo_empty,
`ifdef IO_PORT_OVERFLOW_EN
    input  overflow,
`endif
    input  fifo_full
  );

  // Controller side.
  modport slave (
    input  dev_in, enter_in, in_req, in_ch, new_out, out_ch, out_data,
    output in_ready, in_data, dev_out, enter_out, fifo_empty,
`ifdef IO_PORT_OVERFLOW_EN
    output overflow,
`endif
    output fifo_full
  );
endinterface

// File: rtl/io_port_ctrl.sv
// Multi-channel device I/O controller: per-channel input FIFOs, read FSM, output strobes.
// Latency: read 1 cycle after acceptance when data is buffered; write visible the next cycle.
// Backpressure: in_req is held until in_ready; pushes into a full FIFO are dropped.
// Ports: clk, rst_n (synchronous, active low), bus (io_port_ctrl_if.slave).
// Optional: define IO_PORT_OVERFLOW_EN to add a sticky per-channel bus.overflow flag.
module io_port_ctrl #(
  parameter int N_CH       = 4,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 4,
  parameter int STROBE_LEN = 1
) (
  input logic           clk,
  input logic           rst_n,
  io_port_ctrl_if.slave bus
);
  localparam int CH_W  = $clog2(N_CH);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DELIVER} state_e;

  state_e            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [DATA_W-1:0] in_data_q, in_data_d;
  logic [N_CH-1:0]   enter_prev_q;

  logic [DATA_W-1:0] mem_q    [N_CH][DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q [N_CH];
  logic [PTR_W-1:0]  rd_ptr_q [N_CH];
  logic [CNT_W-1:0]  cnt_q    [N_CH];
  logic [DATA_W-1:0] dev_out_q[N_CH];
  logic [7:0]        strb_q   [N_CH];

  logic [N_CH-1:0]   push, pop, wr_en;
  logic              pop_req;
  logic [CH_W-1:0]   rd_ch;
  logic              rd_avail;
  logic [DATA_W-1:0] rd_head;

  // In IDLE the FSM looks at the live in_ch; afterwards only the latched channel.
  always_comb begin
    rd_ch    = (state_q == IDLE) ? bus.in_ch : ch_q;
    rd_avail = 1'b0;
    rd_head  = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (rd_ch == CH_W'(c)) begin
        rd_avail = (cnt_q[c] != '0);
        rd_head  = mem_q[c][rd_ptr_q[c]];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    in_data_d = in_data_q;
    pop_req   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_req) begin
          ch_d = bus.in_ch;
          if (rd_avail) begin
            state_d   = DELIVER;
            in_data_d = rd_head;
            pop_req   = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!bus.in_req) begin
          state_d = IDLE;
        end else if (rd_avail) begin
          state_d   = DELIVER;
          in_data_d = rd_head;
          pop_req   = 1'b1;
        end
      end
      DELIVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A push into a full FIFO is still accepted when the same channel pops this
  // cycle: the slot being written is the one the head is leaving.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      push[c]  = bus.enter_in[c] & ~enter_prev_q[c];
      pop[c]   = pop_req & (rd_ch == CH_W'(c));
      wr_en[c] = push[c] & ((cnt_q[c] != CNT_W'(DEPTH)) | pop[c]);
    end
  end

  // Storage is not reset; an empty count makes stale words unreachable.
  always_ff @(posedge clk) begin
    for (int c = 0; c < N_CH; c++) begin
      if (wr_en[c]) mem_q[c][wr_ptr_q[c]] <= bus.dev_in[c*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ch_q         <= '0;
      in_data_q    <= '0;
      // All-ones so a level held high through reset is not seen as an edge.
      enter_prev_q <= '1;
      for (int c = 0; c < N_CH; c++) begin
        wr_ptr_q[c]  <= '0;
        rd_ptr_q[c]  <= '0;
        cnt_q[c]     <= '0;
        dev_out_q[c] <= '0;
        strb_q[c]    <= '0;
      end
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      in_data_q    <= in_data_d;
      enter_prev_q <= bus.enter_in;
      for (int c = 0; c < N_CH; c++) begin
        if (wr_en[c]) wr_ptr_q[c] <= wr_ptr_q[c] + PTR_W'(1);
        if (pop[c])   rd_ptr_q[c] <= rd_ptr_q[c] + PTR_W'(1);
        if (wr_en[c] && !pop[c])      cnt_q[c] <= cnt_q[c] + CNT_W'(1);
        else if (!wr_en[c] && pop[c]) cnt_q[c] <= cnt_q[c] - CNT_W'(1);
        // A write restarts the strobe even if one is already running.
        if (bus.new_out && (bus.out_ch == CH_W'(c))) begin
          dev_out_q[c] <= bus.out_data;
          strb_q[c]    <= 8'(STROBE_LEN);
        end else if (strb_q[c] != 8'd0) begin
          strb_q[c] <= strb_q[c] - 8'd1;
        end
      end
    end
  end

  logic [N_CH*DATA_W-1:0] dev_out_flat;
  logic [N_CH-1:0]        enter_out_v, empty_v, full_v;

  // Status flags decode the registered counts, so they reflect the last edge.
  always_comb begin
    dev_out_flat = '0;
    enter_out_v  = '0;
    empty_v      = '0;
    full_v       = '0;
    for (int c = 0; c < N_CH; c++) begin
      dev_out_flat[c*DATA_W +: DATA_W] = dev_out_q[c];
      enter_out_v[c] = (strb_q[c] != 8'd0);
      empty_v[c]     = (cnt_q[c] == '0);
      full_v[c]      = (cnt_q[c] == CNT_W'(DEPTH));
    end
  end

  assign bus.in_ready   = (state_q == DELIVER);
  assign bus.in_data    = in_data_q;
  assign bus.dev_out    = dev_out_flat;
  assign bus.enter_out  = enter_out_v;
  assign bus.fifo_empty = empty_v;
  assign bus.fifo_full  = full_v;

`ifdef IO_PORT_OVERFLOW_EN
  logic [N_CH-1:0] ovf_q;

  // A drop in the same cycle as a delivery from that channel keeps the flag set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (push[c] && !wr_en[c])                          ovf_q[c] <= 1'b1;
        else if (state_q == DELIVER && ch_q == CH_W'(c))   ovf_q[c] <= 1'b0;
      end
    end
  end

  assign bus.overflow = ovf_q;
`endif
endmodule

// File: tb/tb_io_port_ctrl.sv
// Self-checking bench for io_port_ctrl: directed stimulus, scoreboard of expected reads.
// Latency: expected in_ready cycle is recorded with each read and checked by the monitor.
// Backpressure: reads hold in_req until in_ready or a bounded timeout.
module tb_io_port_ctrl;
  localparam int N_CH = 4, DATA_W = 32, DEPTH = 4, STROBE_LEN = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  io_port_ctrl_if #(.N_CH(N_CH), .DATA_W(DATA_W)) bus();

  io_port_ctrl #(.N_CH(N_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .STROBE_LEN(STROBE_LEN)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [DATA_W-1:0] dat;
    int                due;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every in_ready pulse must match the oldest expected read.
  always @(negedge clk) begin
    exp_t e;
    if (bus.in_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL spurious_in_ready: pulse at cycle %0d with data %h, expected no pulse", cyc, bus.in_data);
      end else begin
        e = sb_q.pop_front();
        chk("in_data", 64'(bus.in_data), 64'(e.dat));
        chk("in_ready_cycle", 64'(cyc), 64'(e.due));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input int ch, input logic [DATA_W-1:0] val);
    bus.dev_in[ch*DATA_W +: DATA_W] = val;
    bus.enter_in[ch] = 1'b1;
    tick();
    bus.enter_in[ch] = 1'b0;
    tick();
  endtask

  // Read with data already buffered: accepted at the next edge, pulse right after it.
  task automatic read_ch(input int ch, input logic [DATA_W-1:0] val);
    bit got = 0;
    sb_q.push_back('{dat: val, due: cyc + 1});
    bus.in_ch  = 2'(ch);
    bus.in_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.in_ready === 1'b1) begin
        got = 1;
        break;
      end
    end
    bus.in_req = 1'b0;
    if (!got) begin
      n_checks++;
      $display("FAIL read_timeout: no in_ready for channel %0d, expected data %h", ch, val);
    end
    tick();
  endtask

  task automatic wait_ready(input string name);
    bit got = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.in_ready === 1'b1) begin
        got = 1;
        break;
      end
      tick();
    end
    bus.in_req = 1'b0;
    if (!got) begin
      n_checks++;
      $display("FAIL %s: in_ready never asserted, expected a pulse", name);
    end
    tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'(0));
    chk({tag, "_in_data"}, 64'(bus.in_data), 64'(0));
    chk({tag, "_dev_out"}, {bus.dev_out[63:0]} | {bus.dev_out[127:64]}, 64'(0));
    chk({tag, "_enter_out"}, 64'(bus.enter_out), 64'(0));
    chk({tag, "_fifo_empty"}, 64'(bus.fifo_empty), 64'hF);
    chk({tag, "_fifo_full"}, 64'(bus.fifo_full), 64'(0));
`ifdef IO_PORT_OVERFLOW_EN
    chk({tag, "_overflow"}, 64'(bus.overflow), 64'(0));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.dev_in   = '0;
    bus.enter_in = '0;
    bus.in_req   = 1'b0;
    bus.in_ch    = '0;
    bus.new_out  = 1'b0;
    bus.out_ch   = '0;
    bus.out_data = '0;
    rst_n        = 1'b0;
    tick();
    tick();
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    tick();

    // Single push then read on channel 2.
    bus.dev_in[2*DATA_W +: DATA_W] = 32'hDEADBEEF;
    bus.enter_in[2] = 1'b1;
    tick();
    chk("ch2_not_empty", 64'(bus.fifo_empty[2]), 64'(0));
    bus.enter_in[2] = 1'b0;
    tick();
    read_ch(2, 32'hDEADBEEF);
    chk("ch2_empty_after_read", 64'(bus.fifo_empty[2]), 64'(1));

    // Overfill channel 0.
    for (int v = 1; v <= 5; v++) begin
      push_word(0, 32'(v));
      if (v == 3) chk("ch0_not_full_3", 64'(bus.fifo_full[0]), 64'(0));
      if (v == 4) chk("ch0_full_4", 64'(bus.fifo_full[0]), 64'(1));
`ifdef IO_PORT_OVERFLOW_EN
      if (v == 4) chk("ch0_ovf_4", 64'(bus.overflow[0]), 64'(0));
      if (v == 5) chk("ch0_ovf_5", 64'(bus.overflow[0]), 64'(1));
`endif
    end
    for (int v = 1; v <= 4; v++) read_ch(0, 32'(v));
    chk("ch0_empty_after_4", 64'(bus.fifo_empty[0]), 64'(1));
`ifdef IO_PORT_OVERFLOW_EN
    chk("ch0_ovf_cleared", 64'(bus.overflow[0]), 64'(0));
`endif

    // Request on empty channel 1; data arrives while waiting.
    bus.in_ch  = 2'd1;
    bus.in_req = 1'b1;
    tick();
    tick();
    tick();
    bus.dev_in[1*DATA_W +: DATA_W] = 32'h55;
    bus.enter_in[1] = 1'b1;
    sb_q.push_back('{dat: 32'h55, due: cyc + 2});
    tick();
    bus.enter_in[1] = 1'b0;
    wait_ready("wait_read_timeout");

    // Request abandoned while waiting: later data stays buffered, no pulse.
    bus.in_ch  = 2'd1;
    bus.in_req = 1'b1;
    tick();
    tick();
    bus.in_req = 1'b0;
    tick();
    push_word(1, 32'h77);
    tick();
    tick();
    chk("ch1_kept_after_abort", 64'(bus.fifo_empty[1]), 64'(0));
    read_ch(1, 32'h77);

    // Full channel 3 with simultaneous push and pop.
    for (int v = 0; v < 4; v++) push_word(3, 32'h31 + 32'(v));
    chk("ch3_full", 64'(bus.fifo_full[3]), 64'(1));
    bus.dev_in[3*DATA_W +: DATA_W] = 32'hA;
    bus.enter_in[3] = 1'b1;
    bus.in_ch  = 2'd3;
    bus.in_req = 1'b1;
    sb_q.push_back('{dat: 32'h31, due: cyc + 1});
    tick();
    bus.in_req = 1'b0;
    bus.enter_in[3] = 1'b0;
    chk("ch3_still_full", 64'(bus.fifo_full[3]), 64'(1));
    tick();
    read_ch(3, 32'h32);
    read_ch(3, 32'h33);
    read_ch(3, 32'h34);
    read_ch(3, 32'hA);
    chk("ch3_empty_end", 64'(bus.fifo_empty[3]), 64'(1));

    // Plain strobe on channel 2.
    bus.new_out  = 1'b1;
    bus.out_ch   = 2'd2;
    bus.out_data = 32'hCAFE;
    tick();
    bus.new_out = 1'b0;
    chk("dev_out2", 64'(bus.dev_out[2*DATA_W +: DATA_W]), 64'hCAFE);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("strobe2_c%0d", i), 64'(bus.enter_out[2]), 64'(i < 3));
      tick();
    end

    // Strobe on channel 1 restarted by a rewrite in its second cycle.
    bus.new_out  = 1'b1;
    bus.out_ch   = 2'd1;
    bus.out_data = 32'h1234;
    tick();
    bus.new_out = 1'b0;
    chk("dev_out1_first", 64'(bus.dev_out[1*DATA_W +: DATA_W]), 64'h1234);
    chk("enter_out_only1", 64'(bus.enter_out), 64'h2);
    tick();
    chk("strobe1_second", 64'(bus.enter_out[1]), 64'(1));
    bus.new_out  = 1'b1;
    bus.out_data = 32'h5678;
    tick();
    bus.new_out = 1'b0;
    chk("dev_out1_rewrite", 64'(bus.dev_out[1*DATA_W +: DATA_W]), 64'h5678);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("strobe1_re_c%0d", i), 64'(bus.enter_out[1]), 64'(i < 3));
      tick();
    end

    // Reset in the middle of a pending read, with buffered data, an active
    // strobe and enter_in[0] held high across reset.
    push_word(2, 32'h99);
    bus.in_ch    = 2'd1;
    bus.in_req   = 1'b1;
    bus.new_out  = 1'b1;
    bus.out_ch   = 2'd0;
    bus.out_data = 32'hFFFF;
    bus.dev_in[0 +: DATA_W] = 32'h42;
    bus.enter_in[0] = 1'b1;
    tick();
    bus.new_out = 1'b0;
    chk("strobe0_active", 64'(bus.enter_out[0]), 64'(1));
    rst_n = 1'b0;
    tick();
    bus.in_req = 1'b0;
    chk_reset_outputs("midrst");
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    chk("no_push_held_level", 64'(bus.fifo_empty), 64'hF);
    bus.enter_in[0] = 1'b0;
    tick();
    push_word(0, 32'h43);
    read_ch(0, 32'h43);

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) tick();
    chk("scoreboard_drained", 64'(sb_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
